regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/mips_pkg.sv | 14 +
 rtl/regfile_wb_arbiter.sv | 104 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline writeback path.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
    localparam int DROP_CNT_W = 8;

    // Identity of the requester that most recently won arbitration.
    typedef enum logic {
        GRANT_REQ0 = 1'b0,
        GRANT_REQ1 = 1'b1
    } grant_t;

endpackage

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges the ALU and load/multi-cycle writeback requests
// into the single register-file write port, with forwarding of the pending write.
module regfile_wb_arbiter
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  req0_valid,
    input  logic [REG_ADDR_W-1:0] req0_addr,
    input  logic [WIDTH-1:0]      req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [REG_ADDR_W-1:0] req1_addr,
    input  logic [WIDTH-1:0]      req1_data,
    output logic                  req1_ready,
    input  logic [REG_ADDR_W-1:0] rd_a1,
    input  logic [REG_ADDR_W-1:0] rd_a2,
    output logic                  fwd1_hit,
    output logic                  fwd2_hit,
    output logic [WIDTH-1:0]      fwd_data,
    output logic                  we3,
    output logic [REG_ADDR_W-1:0] A3,
    output logic [WIDTH-1:0]      WD3,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    grant_t                last_grant;
    logic                  grant0;
    logic                  grant1;
    logic                  accept;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_data;

    // Round-robin pick: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = (last_grant == GRANT_REQ1);
            grant1 = (last_grant == GRANT_REQ0);
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    // Ready is gated by hold and by reset so nothing is accepted while either is high.
    assign req0_ready = grant0 && !hold && !rst;
    assign req1_ready = grant1 && !hold && !rst;
    assign accept     = req0_ready || req1_ready;

    // Steer the accepted request's address and data toward the write registers.
    always_comb begin
        sel_addr = req0_addr;
        sel_data = req0_data;
        if (req1_ready) begin
            sel_addr = req1_addr;
            sel_data = req1_data;
        end
    end

    // Last-grant pointer moves only when a request is actually accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GRANT_REQ1;
        end else if (req0_ready) begin
            last_grant <= GRANT_REQ0;
        end else if (req1_ready) begin
            last_grant <= GRANT_REQ1;
        end
    end

    // Register the write one cycle after acceptance; A3/WD3 hold when nothing is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3 <= 1'b0;
            A3  <= '0;
            WD3 <= '0;
        end else begin
            we3 <= accept && (sel_addr != REG_ZERO);
            if (accept && (sel_addr != REG_ZERO)) begin
                A3  <= sel_addr;
                WD3 <= sel_data;
            end
        end
    end

    // Count accepted writes to register 0, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (accept && (sel_addr == REG_ZERO) && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign fwd1_hit = we3 && (rd_a1 == A3) && (rd_a1 != REG_ZERO);
    assign fwd2_hit = we3 && (rd_a2 == A3) && (rd_a2 != REG_ZERO);
    assign fwd_data = WD3;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the arbiter.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic [4:0]  rd_a1;
    logic [4:0]  rd_a2;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd_data;
    logic        we3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int          m_last;
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    int          m_drop;

    // Writes that actually reach register 9 of a register file hanging off the port.
    int rf9_writes = 0;

    regfile_wb_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .hold       (hold),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rd_a1      (rd_a1),
        .rd_a2      (rd_a2),
        .fwd1_hit   (fwd1_hit),
        .fwd2_hit   (fwd2_hit),
        .fwd_data   (fwd_data),
        .we3        (we3),
        .A3         (A3),
        .WD3        (WD3),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we3 && A3 == 5'd9) rf9_writes <= rf9_writes + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 1;
        m_we   = 1'b0;
        m_a3   = '0;
        m_wd   = '0;
        m_drop = 0;
    endtask

    task automatic chk_fwd(input logic [4:0] a1, input logic [4:0] a2);
        rd_a1 = a1;
        rd_a2 = a2;
        #1;
        chk("fwd1_hit", fwd1_hit, m_we && a1 == m_a3 && a1 != 0);
        chk("fwd2_hit", fwd2_hit, m_we && a2 == m_a3 && a2 != 0);
        chk("fwd_data", fwd_data, m_wd);
    endtask

    // One clock: check readies against the model's choice, clock, then check outputs.
    // g returns the granted requester (0/1) or -1 for no acceptance.
    task automatic cycle(output int g);
        logic [4:0]  ad;
        logic [31:0] dt;
        #1;
        g = -1;
        if (!hold && !rst) begin
            if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
        end
        chk("req0_ready", req0_ready, g == 0);
        chk("req1_ready", req1_ready, g == 1);
        ad = (g == 1) ? req1_addr : req0_addr;
        dt = (g == 1) ? req1_data : req0_data;
        @(posedge clk);
        #1;
        m_we = 1'b0;
        if (g >= 0) begin
            m_last = g;
            if (ad != 0) begin
                m_we = 1'b1;
                m_a3 = ad;
                m_wd = dt;
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
        chk("we3", we3, m_we);
        chk("A3", A3, m_a3);
        chk("WD3", WD3, m_wd);
        chk("drop_cnt", drop_cnt, m_drop);
    endtask

    initial begin
        int g;
        bool_pending: begin end
        rst = 1'b1; hold = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h1;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h2;
        rd_a1 = '0; rd_a2 = '0;
        model_reset();

        // Reset state: outputs cleared, nothing accepted while rst is high.
        repeat (2) cycle(g);
        chk("reset_no_grant", g, -1);
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle(g);

        // Single request on requester 0.
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        cycle(g);
        chk("single_grant", g, 0);
        chk("single_we3", we3, 1);
        chk("single_A3", A3, 5);
        chk("single_WD3", WD3, 32'hDEADBEEF);
        req0_valid = 1'b0;
        cycle(g);

        // Contention right after reset: grants alternate 0,1,0,1.
        rst = 1'b1; #2; rst = 1'b0;
        model_reset();
        chk("reset_we3", we3, 0);
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hA0;
        req1_valid = 1'b1; req1_addr = 5'd20; req1_data = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            cycle(g);
            chk("contention_grant", g, i % 2);
            chk("contention_we3", we3, 1);
            if (g == 0) begin req0_addr = req0_addr + 1; req0_data = req0_data + 1; end
            else        begin req1_addr = req1_addr + 1; req1_data = req1_data + 1; end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle(g);

        // Register 0 writes are dropped and counted, saturating at 255.
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
        cycle(g);
        chk("drop_we3", we3, 0);
        chk("drop_first", drop_cnt, 1);
        repeat (299) cycle(g);
        chk("drop_saturate", drop_cnt, 255);
        req1_valid = 1'b0;
        cycle(g);

        // Forwarding of a pending write.
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hA5A5A5A5;
        cycle(g);
        req0_valid = 1'b0;
        chk_fwd(5'd7, 5'd0);
        chk("fwd_dir_hit1", fwd1_hit, 1);
        chk("fwd_dir_hit2", fwd2_hit, 0);
        chk("fwd_dir_data", fwd_data, 32'hA5A5A5A5);
        cycle(g);
        chk_fwd(5'd7, 5'd7);

        // Hold: in-flight write from requester 1 completes, then nothing is accepted.
        req1_valid = 1'b1; req1_addr = 5'd12; req1_data = 32'hC0FFEE;
        cycle(g);
        chk("hold_inflight_we3", we3, 1);
        hold = 1'b1; req0_valid = 1'b1; req0_addr = 5'd13; req0_data = 32'h13;
        for (int i = 0; i < 3; i++) begin
            cycle(g);
            chk("hold_no_grant", g, -1);
            chk("hold_we3", we3, 0);
        end
        hold = 1'b0;
        #1;
        chk("release_ready0", req0_ready, 1);
        chk("release_ready1", req1_ready, 0);
        cycle(g);
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle(g);

        // Async reset between edges discards the pending write to register 9.
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
        cycle(g);
        chk("async_pre_we3", we3, 1);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_we3", we3, 0);
        chk("async_A3", A3, 0);
        chk("async_WD3", WD3, 0);
        chk("async_ready0", req0_ready, 0);
        chk("async_ready1", req1_ready, 0);
        cycle(g);
        chk("async_rf9_unchanged", rf9_writes, 0);
        rst = 1'b0;
        req0_valid = 1'b0;
        cycle(g);

        // Randomized traffic; requesters hold their request until accepted.
        for (int i = 0; i < 400; i++) begin
            hold = ($urandom % 6) == 0;
            if (!req0_valid || g == 0) begin
                req0_valid = $urandom % 2;
                req0_addr  = $urandom % 32;
                req0_data  = $urandom;
            end
            if (!req1_valid || g == 1) begin
                req1_valid = $urandom % 2;
                req1_addr  = $urandom % 32;
                req1_data  = $urandom;
            end
            cycle(g);
            chk_fwd(($urandom % 2) ? m_a3 : 5'($urandom % 32),
                    ($urandom % 2) ? m_a3 : 5'($urandom % 32));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
